mux_select_ctrl: RTL and testbench
==================================

// Module: mux_select_ctrl
// PURPOSE
//   Upstream control stage for the 2:1 bit mux. Turns a raw, bouncing, active-low pushbutton
//   into a clean select line `sel` that drives the mux `s` input.
//   Each debounced press toggles `sel`. An optional auto mode also toggles `sel` every
//   AUTO_PERIOD clocks, which is useful for board demos.
//   Also reports a one-cycle change strobe and a wrapping press counter for LED display.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000    consecutive stable samples needed to accept a level (10 ms @ 50 MHz); >=2
//   AUTO_PERIOD      50000000  clocks between auto toggles (1 s @ 50 MHz); >=2
//   CNT_W            8         width of press_count
// PORTS
//   clock        in   1      system clock, all state on posedge
//   reset        in   1      asynchronous, active-high reset
//   btn_n        in   1      raw pushbutton, 0 = pressed, asynchronous to clock
//   auto_en      in   1      raw slide switch, 1 = auto-toggle enabled, asynchronous
//   sel          out  1      mux select; 0 = pass x, 1 = pass y
//   sel_pulse    out  1      high for exactly the first cycle on which sel holds a new value
//   press_count  out  CNT_W  number of accepted presses, modulo 2^CNT_W
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - sel=0, sel_pulse=0, press_count=0.
//     - Synchronizers =0 (released/disabled). Debounce counter=0. Auto divider=0.
//     - Debounce FSM resets to DOWN, so a press must first be seen released before it can count.
//   Synchronizers: btn_n (inverted to btn) and auto_en each pass through 2 flops; only synced values are used.
//   Debounce FSM, 4 states, per-cycle counter dcnt:
//     - IDLE_UP: go to WAIT_DN when btn_s=1.
//     - WAIT_DN: dcnt++ while btn_s=1. If btn_s=0, dcnt=0 and return to IDLE_UP.
//       When dcnt reaches DEBOUNCE_CYCLES-1 with btn_s=1, go to DOWN and raise press (1 cycle).
//     - DOWN: go to WAIT_UP when btn_s=0.
//     - WAIT_UP: mirror of WAIT_DN. Reaching the count returns to IDLE_UP with no event.
//       btn_s=1 returns to DOWN.
//     - dcnt clears on every state entry. A glitch shorter than DEBOUNCE_CYCLES never produces a press.
//   Latency: btn_n falls before edge 0 and stays low -> press is registered and sel toggles at edge DEBOUNCE_CYCLES+3.
//   Auto divider:
//     - While auto_s=1, adiv counts 0..AUTO_PERIOD-1 and wraps; tick=1 on the wrap cycle.
//     - While auto_s=0, adiv is held at 0 and tick=0.
//     - First tick comes AUTO_PERIOD cycles after auto_s rises.
//   Toggle rule:
//     - toggle = press | tick. On toggle, sel<=~sel and sel_pulse<=1; otherwise sel_pulse<=0.
//     - press and tick on the same cycle -> a single toggle only (OR, never a double flip).
//   Counter:
//     - press_count increments on press only; auto ticks never count.
//     - Wraps from 2^CNT_W-1 to 0 silently.
//   Reset mid-operation (mid-debounce or mid-period):
//     - Outputs clear immediately and the in-flight press/tick is discarded.
//     - A button held through reset release is not counted until it is released and pressed again.
//   All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//   Shared header mux_ctrl_defs.vh:
//     - debounce state encodings ST_IDLE_UP=2'd0, ST_WAIT_DN=2'd1, ST_DOWN=2'd2, ST_WAIT_UP=2'd3.
//     - default timing constants for 50 MHz.
//   Sub-module key_debounce (clock, reset, raw_n, press): holds the synchronizer, FSM and dcnt.
//     Reusable for the other KEY inputs.
//   Top level holds the auto_en synchronizer, the auto divider, the toggle register and press_count.
//   Counter widths come from $clog2 of the parameters.
// TESTING (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, CNT_W=4)
//   1. Reset, then btn_n=1 and auto_en=0 for 20 cycles
//      -> sel=0, sel_pulse never high, press_count=0; FSM settles in IDLE_UP.
//   2. btn_n=0 for 3 cycles then 1 (bounce), repeated 5 times
//      -> no toggle; press_count=0.
//   3. btn_n held 0 from edge 0
//      -> sel=1 and sel_pulse=1 at edge 7 only; press_count=1. Holding 50 more cycles gives no further change.
//   4. 17 clean presses (each 6 low / 6 high cycles)
//      -> press_count wraps 15->0->1; sel=1; exactly 17 sel_pulse strobes.
//   5. auto_en=1 for 40 cycles with no press -> sel toggles every 8 cycles and press_count stays 0.
//      Force a press on a tick cycle -> one toggle, press_count+1.
//   6. Assert reset with btn_n held low during WAIT_DN, release reset, keep btn_n low 20 cycles
//      -> all outputs 0, no press.
//      Then btn_n high for 6 cycles and low for 6 -> exactly 1 press.

Source files
------------

// File: rtl/mux_select_ctrl_pkg.sv
// Shared definitions for the mux select control block: debounce FSM encoding,
// default 50 MHz timing constants and a counter-width helper.
package mux_select_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_UP = 2'd0,
        ST_WAIT_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_WAIT_UP = 2'd3
    } deb_state_t;

    // 10 ms debounce and 1 s auto-toggle at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_AUTO_PERIOD     = 50000000;
    localparam int DEF_CNT_W           = 8;

    localparam int SYNC_STAGES = 2;

    // Width of a counter that must hold 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_select_ctrl_debounce.sv
// Debouncer for one raw active-low key: two-flop synchronizer, four-state
// hysteresis FSM and a one-cycle registered press strobe.
module key_debounce
    import mux_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
(
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic press
);

    localparam int                DCNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_s;

    deb_state_t        state_reg, state_next;
    logic [DCNT_W-1:0] dcnt_reg, dcnt_next;
    logic              press_reg, press_next;

    // Inverted on entry so the rest of the logic sees 1 = pressed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ~raw_n};
        end
    end

    assign btn_s = sync_reg[SYNC_STAGES-1];

    // Starting in DOWN forces a key held through reset to be released first
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_DOWN;
            dcnt_reg  <= '0;
            press_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dcnt_reg  <= dcnt_next;
            press_reg <= press_next;
        end
    end

    // dcnt defaults to zero so it is cleared on every state change
    always_comb begin
        state_next = state_reg;
        dcnt_next  = '0;
        press_next = 1'b0;
        case (state_reg)
            ST_IDLE_UP: begin
                if (btn_s) begin
                    state_next = ST_WAIT_DN;
                end
            end
            ST_WAIT_DN: begin
                if (!btn_s) begin
                    state_next = ST_IDLE_UP;
                end else if (dcnt_reg == DCNT_LAST) begin
                    state_next = ST_DOWN;
                    press_next = 1'b1;
                end else begin
                    dcnt_next = dcnt_reg + DCNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (!btn_s) begin
                    state_next = ST_WAIT_UP;
                end
            end
            ST_WAIT_UP: begin
                if (btn_s) begin
                    state_next = ST_DOWN;
                end else if (dcnt_reg == DCNT_LAST) begin
                    state_next = ST_IDLE_UP;
                end else begin
                    dcnt_next = dcnt_reg + DCNT_W'(1);
                end
            end
            default: begin
                state_next = ST_DOWN;
            end
        endcase
    end

    assign press = press_reg;

endmodule

// File: rtl/mux_select_ctrl.sv
// Select-line controller for the 2:1 mux: debounced key toggles sel, an optional
// auto divider toggles it periodically, and accepted presses are counted.
module mux_select_ctrl
    import mux_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int AUTO_PERIOD     = DEF_AUTO_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_n,
    input  logic             auto_en,
    output logic             sel,
    output logic             sel_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int                ADIV_W    = cnt_width(AUTO_PERIOD);
    localparam logic [ADIV_W-1:0] ADIV_LAST = ADIV_W'(AUTO_PERIOD - 1);

    logic [1:0]             rst_sync_reg;
    logic                   rst_int;
    logic [SYNC_STAGES-1:0] auto_sync_reg;
    logic                   auto_s;
    logic [ADIV_W-1:0]      adiv_reg;
    logic                   tick;
    logic                   press;
    logic                   toggle;
    logic                   sel_reg;
    logic                   pulse_reg;
    logic [CNT_W-1:0]       count_reg;

    // Reset asserts at once everywhere but releases aligned to the clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_sync_reg <= 2'b11;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_reg[1];

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clock(clock),
        .reset(rst_int),
        .raw_n(btn_n),
        .press(press)
    );

    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            auto_sync_reg <= '0;
        end else begin
            auto_sync_reg <= {auto_sync_reg[SYNC_STAGES-2:0], auto_en};
        end
    end

    assign auto_s = auto_sync_reg[SYNC_STAGES-1];

    // Divider parks at zero while disabled so the first tick is a full period out
    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            adiv_reg <= '0;
        end else if (!auto_s || adiv_reg == ADIV_LAST) begin
            adiv_reg <= '0;
        end else begin
            adiv_reg <= adiv_reg + ADIV_W'(1);
        end
    end

    assign tick   = auto_s && (adiv_reg == ADIV_LAST);
    assign toggle = press | tick;

    // A coincident press and tick collapse into a single flip
    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            sel_reg   <= 1'b0;
            pulse_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            pulse_reg <= toggle;
            if (toggle) begin
                sel_reg <= ~sel_reg;
            end
            if (press) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign sel         = sel_reg;
    assign sel_pulse   = pulse_reg;
    assign press_count = count_reg;

endmodule

// File: tb/tb_mux_select_ctrl.sv
// Scoreboard bench for mux_select_ctrl with short debounce and auto periods.
`timescale 1ns/1ps
module tb_mux_select_ctrl;

    localparam int DEB = 4;
    localparam int PER = 8;
    localparam int CW  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          btn_n;
    logic          auto_en;
    logic          sel;
    logic          sel_pulse;
    logic [CW-1:0] press_count;

    mux_select_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_PERIOD(PER),
        .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_n(btn_n),
        .auto_en(auto_en),
        .sel(sel),
        .sel_pulse(sel_pulse),
        .press_count(press_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct packed {
        logic [31:0]   at;
        logic          s;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expect_toggle(input int at, input logic s, input logic [CW-1:0] c);
        exp_t e;
        e.at  = 32'(at);
        e.s   = s;
        e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_outs(input string name, input logic s, input logic p, input logic [CW-1:0] c);
        vectors++;
        if (sel !== s || sel_pulse !== p || press_count !== c) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got sel=%0b pulse=%0b count=%0d, required sel=%0b pulse=%0b count=%0d",
                     name, cyc, sel, sel_pulse, press_count, s, p, c);
        end
    endtask

    // Monitor: every strobe must match the oldest expected toggle, on its cycle
    always @(negedge clock) begin
        exp_t e;
        if (sel_pulse === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse cyc=%0d: got sel=%0b count=%0d, required no strobe",
                         cyc, sel, press_count);
            end else begin
                e = sb_q.pop_front();
                if (32'(cyc) != e.at || sel !== e.s || press_count !== e.cnt) begin
                    miscompares++;
                    $display("FAIL toggle: got cyc=%0d sel=%0b count=%0d, required cyc=%0d sel=%0b count=%0d",
                             cyc, sel, press_count, e.at, e.s, e.cnt);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].at < 32'(cyc)) begin
            e = sb_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse: got no strobe by cyc=%0d, required strobe at cyc=%0d sel=%0b count=%0d",
                     cyc, e.at, e.s, e.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish by %0t, required completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        btn_n   = 1'b1;
        auto_en = 1'b0;
        reset   = 1'b0;
        #1 reset = 1'b1;
        #1 check_outs("reset_state", 1'b0, 1'b0, 4'd0);
        tick_n(3);
        reset = 1'b0;

        // Idle: nothing may toggle
        tick_n(20);
        check_outs("idle", 1'b0, 1'b0, 4'd0);

        // Bounces of 3 low samples are shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            btn_n = 1'b0;
            tick_n(3);
            btn_n = 1'b1;
            tick_n(3);
        end
        tick_n(10);
        check_outs("bounce", 1'b0, 1'b0, 4'd0);

        // Held press: toggle at edge 7 relative to the first edge seeing btn_n low
        c = cyc;
        expect_toggle(c + 8, 1'b1, 4'd1);
        btn_n = 1'b0;
        tick_n(58);
        check_outs("held", 1'b1, 1'b0, 4'd1);
        btn_n = 1'b1;
        tick_n(12);

        // Fresh start, then 17 clean presses wrapping the 4-bit counter
        reset = 1'b1;
        #1 check_outs("reset_again", 1'b0, 1'b0, 4'd0);
        tick_n(2);
        reset = 1'b0;
        tick_n(20);
        for (int k = 1; k <= 17; k++) begin
            c = cyc;
            expect_toggle(c + 8, 1'(k % 2), CW'(k % 16));
            btn_n = 1'b0;
            tick_n(6);
            btn_n = 1'b1;
            tick_n(6);
        end
        tick_n(4);
        check_outs("wrap", 1'b1, 1'b0, 4'd1);

        // Auto mode: first toggle 10 edges after auto_en rises, then every 8
        c = cyc;
        auto_en = 1'b1;
        expect_toggle(c + 10, 1'b0, 4'd1);
        expect_toggle(c + 18, 1'b1, 4'd1);
        expect_toggle(c + 26, 1'b0, 4'd1);
        expect_toggle(c + 34, 1'b1, 4'd1);
        expect_toggle(c + 42, 1'b0, 4'd1);
        tick_n(40);
        auto_en = 1'b0;
        tick_n(12);
        check_outs("auto", 1'b0, 1'b0, 4'd1);

        // Press lands on the same cycle as a tick: single flip, counted once
        c = cyc;
        auto_en = 1'b1;
        tick_n(2);
        btn_n = 1'b0;
        expect_toggle(c + 10, 1'b1, 4'd2);
        expect_toggle(c + 18, 1'b0, 4'd2);
        tick_n(6);
        btn_n = 1'b1;
        tick_n(10);
        auto_en = 1'b0;
        tick_n(12);
        check_outs("coincide", 1'b0, 1'b0, 4'd2);

        // Reset in WAIT_DN with the key held through release
        btn_n = 1'b0;
        tick_n(4);
        reset = 1'b1;
        #1 check_outs("reset_mid", 1'b0, 1'b0, 4'd0);
        tick_n(2);
        reset = 1'b0;
        tick_n(20);
        check_outs("held_through_reset", 1'b0, 1'b0, 4'd0);
        btn_n = 1'b1;
        tick_n(6);
        c = cyc;
        btn_n = 1'b0;
        expect_toggle(c + 8, 1'b1, 4'd1);
        tick_n(6);
        btn_n = 1'b1;
        tick_n(12);
        check_outs("after_reset_press", 1'b1, 1'b0, 4'd1);

        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending toggles, required 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
